// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Execute slice of the 5-stage scalar/vector CPU. It holds the Decode/Execute
//   pipeline register, the operand forwarding muxes, one 8-bit scalar ALU, LANES
//   replicated 8-bit lane ALUs, and the Execute/Memory pipeline register.
//
// Ports
//   clk, reset                 : rising-edge clock, async active-high reset
//   control_in[15:0]           : decoded control word (0 = NOP)
//   srcA_in, srcB_in           : scalar operands from the register file
//   srcA/B_vector_in           : vector operands (lane i at [8i+7:8i])
//   rs1/rs2/rd_decode          : register indices from Decode
//   writeback_data             : forwarding source from Writeback
//   select_forward_mux_A/B     : forwarding selects (1=WB, 2=MEM, else D/E)
//   *_execute                  : Decode/Execute register contents
//   alu_result_execute         : combinational scalar ALU result
//   *_memory                   : Execute/Memory register contents
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int LANES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          control_in,
  input  logic [7:0]           srcA_in,
  input  logic [7:0]           srcB_in,
  input  logic [8*LANES-1:0]   srcA_vector_in,
  input  logic [8*LANES-1:0]   srcB_vector_in,
  input  logic [4:0]           rs1_decode,
  input  logic [4:0]           rs2_decode,
  input  logic [4:0]           rd_decode,
  input  logic [7:0]           writeback_data,
  input  logic [2:0]           select_forward_mux_A,
  input  logic [2:0]           select_forward_mux_B,
  output logic                 wre_execute,
  output logic                 vector_wre_execute,
  output logic                 write_memory_enable_execute,
  output logic                 load_instruction,
  output logic [1:0]           select_writeback_data_mux_execute,
  output logic [3:0]           aluOp_execute,
  output logic [4:0]           rs1_execute,
  output logic [4:0]           rs2_execute,
  output logic [4:0]           rd_execute,
  output logic [7:0]           alu_result_execute,
  output logic                 wre_memory,
  output logic                 vector_wre_memory,
  output logic                 write_memory_enable_memory,
  output logic [1:0]           select_writeback_data_mux_memory,
  output logic [4:0]           rs1_memory,
  output logic [4:0]           rs2_memory,
  output logic [4:0]           rd_memory,
  output logic [7:0]           alu_result_memory,
  output logic [7:0]           srcA_memory,
  output logic [7:0]           srcB_memory,
  output logic [8*LANES-1:0]   vector_data_memory,
  output logic [11:0]          vector_address_data_memory
);

  localparam int VW = 8 * LANES;

  // Shared 8-bit ALU used by the scalar path and every vector lane.
  function automatic logic [7:0] alu8(input logic [3:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, a} * {8'd0, b};
    case (op)
      4'd0:    alu8 = a + b;
      4'd1:    alu8 = a - b;
      4'd2:    alu8 = a & b;
      4'd3:    alu8 = a | b;
      4'd4:    alu8 = a ^ b;
      4'd5:    alu8 = a << b[2:0];
      4'd6:    alu8 = a >> b[2:0];
      4'd7:    alu8 = b;
      4'd8:    alu8 = prod[7:0];
      default: alu8 = 8'd0;
    endcase
  endfunction

  // Decode/Execute register state
  logic          wre_q, vwre_q, wme_q, load_q;
  logic [1:0]    sel_wb_q;
  logic [3:0]    alu_op_q;
  logic [7:0]    src_a_q, src_b_q;
  logic [VW-1:0] vec_a_q, vec_b_q;
  logic [4:0]    rs1_q, rs2_q, rd_q;

  // Execute/Memory register state
  logic          wre_m_q, vwre_m_q, wme_m_q;
  logic [1:0]    sel_wb_m_q;
  logic [4:0]    rs1_m_q, rs2_m_q, rd_m_q;
  logic [7:0]    alu_m_q, src_a_m_q, src_b_m_q;
  logic [VW-1:0] vec_m_q;
  logic [11:0]   vaddr_m_q;

  // Execute-stage combinational values (next state of the E/M register)
  logic [7:0]    fwd_a_d, fwd_b_d, alu_d;
  logic [VW-1:0] vec_d;

  // Reserved control bits carry no meaning in this stage.
  logic unused_reserved_s;
  assign unused_reserved_s = ^control_in[15:10];

  // Decode/Execute pipeline register: no enable, bubbles arrive as control 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wre_q    <= 1'b0;
      vwre_q   <= 1'b0;
      wme_q    <= 1'b0;
      load_q   <= 1'b0;
      sel_wb_q <= 2'd0;
      alu_op_q <= 4'd0;
      src_a_q  <= 8'd0;
      src_b_q  <= 8'd0;
      vec_a_q  <= '0;
      vec_b_q  <= '0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rd_q     <= 5'd0;
    end else begin
      wre_q    <= control_in[0];
      vwre_q   <= control_in[1];
      wme_q    <= control_in[2];
      sel_wb_q <= control_in[4:3];
      alu_op_q <= control_in[8:5];
      load_q   <= control_in[9];
      src_a_q  <= srcA_in;
      src_b_q  <= srcB_in;
      vec_a_q  <= srcA_vector_in;
      vec_b_q  <= srcB_vector_in;
      rs1_q    <= rs1_decode;
      rs2_q    <= rs2_decode;
      rd_q     <= rd_decode;
    end
  end

  // Forwarding muxes: unused select codes fall back to the D/E operand.
  always_comb begin
    fwd_a_d = src_a_q;
    fwd_b_d = src_b_q;
    case (select_forward_mux_A)
      3'd1:    fwd_a_d = writeback_data;
      3'd2:    fwd_a_d = alu_m_q;
      default: fwd_a_d = src_a_q;
    endcase
    case (select_forward_mux_B)
      3'd1:    fwd_b_d = writeback_data;
      3'd2:    fwd_b_d = alu_m_q;
      default: fwd_b_d = src_b_q;
    endcase
  end

  // Scalar ALU on forwarded operands; each lane works on its own unforwarded
  // D/E vector slice so no carry crosses a lane boundary.
  always_comb begin
    alu_d = alu8(alu_op_q, fwd_a_d, fwd_b_d);
    vec_d = '0;
    for (int i = 0; i < LANES; i++) begin
      vec_d[8*i +: 8] = alu8(alu_op_q, vec_a_q[8*i +: 8], vec_b_q[8*i +: 8]);
    end
  end

  // Execute/Memory pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wre_m_q    <= 1'b0;
      vwre_m_q   <= 1'b0;
      wme_m_q    <= 1'b0;
      sel_wb_m_q <= 2'd0;
      rs1_m_q    <= 5'd0;
      rs2_m_q    <= 5'd0;
      rd_m_q     <= 5'd0;
      alu_m_q    <= 8'd0;
      src_a_m_q  <= 8'd0;
      src_b_m_q  <= 8'd0;
      vec_m_q    <= '0;
      vaddr_m_q  <= 12'd0;
    end else begin
      wre_m_q    <= wre_q;
      vwre_m_q   <= vwre_q;
      wme_m_q    <= wme_q;
      sel_wb_m_q <= sel_wb_q;
      rs1_m_q    <= rs1_q;
      rs2_m_q    <= rs2_q;
      rd_m_q     <= rd_q;
      alu_m_q    <= alu_d;
      src_a_m_q  <= fwd_a_d;
      src_b_m_q  <= fwd_b_d;
      vec_m_q    <= vec_d;
      vaddr_m_q  <= {4'b0000, fwd_a_d};
    end
  end

  assign wre_execute                       = wre_q;
  assign vector_wre_execute                = vwre_q;
  assign write_memory_enable_execute       = wme_q;
  assign load_instruction                  = load_q;
  assign select_writeback_data_mux_execute = sel_wb_q;
  assign aluOp_execute                     = alu_op_q;
  assign rs1_execute                       = rs1_q;
  assign rs2_execute                       = rs2_q;
  assign rd_execute                        = rd_q;
  assign alu_result_execute                = alu_d;

  assign wre_memory                        = wre_m_q;
  assign vector_wre_memory                 = vwre_m_q;
  assign write_memory_enable_memory        = wme_m_q;
  assign select_writeback_data_mux_memory  = sel_wb_m_q;
  assign rs1_memory                        = rs1_m_q;
  assign rs2_memory                        = rs2_m_q;
  assign rd_memory                         = rd_m_q;
  assign alu_result_memory                 = alu_m_q;
  assign srcA_memory                       = src_a_m_q;
  assign srcB_memory                       = src_b_m_q;
  assign vector_data_memory                = vec_m_q;
  assign vector_address_data_memory        = vaddr_m_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  control_in;
  logic [7:0]   srcA_in, srcB_in;
  logic [127:0] srcA_vector_in, srcB_vector_in;
  logic [4:0]   rs1_decode, rs2_decode, rd_decode;
  logic [7:0]   writeback_data;
  logic [2:0]   select_forward_mux_A, select_forward_mux_B;
  logic         wre_execute, vector_wre_execute, write_memory_enable_execute, load_instruction;
  logic [1:0]   select_writeback_data_mux_execute;
  logic [3:0]   aluOp_execute;
  logic [4:0]   rs1_execute, rs2_execute, rd_execute;
  logic [7:0]   alu_result_execute;
  logic         wre_memory, vector_wre_memory, write_memory_enable_memory;
  logic [1:0]   select_writeback_data_mux_memory;
  logic [4:0]   rs1_memory, rs2_memory, rd_memory;
  logic [7:0]   alu_result_memory, srcA_memory, srcB_memory;
  logic [127:0] vector_data_memory;
  logic [11:0]  vector_address_data_memory;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_stage #(.LANES(16)) dut (
    .clk(clk), .reset(reset), .control_in(control_in),
    .srcA_in(srcA_in), .srcB_in(srcB_in),
    .srcA_vector_in(srcA_vector_in), .srcB_vector_in(srcB_vector_in),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
    .writeback_data(writeback_data),
    .select_forward_mux_A(select_forward_mux_A), .select_forward_mux_B(select_forward_mux_B),
    .wre_execute(wre_execute), .vector_wre_execute(vector_wre_execute),
    .write_memory_enable_execute(write_memory_enable_execute), .load_instruction(load_instruction),
    .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
    .aluOp_execute(aluOp_execute),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .alu_result_execute(alu_result_execute),
    .wre_memory(wre_memory), .vector_wre_memory(vector_wre_memory),
    .write_memory_enable_memory(write_memory_enable_memory),
    .select_writeback_data_mux_memory(select_writeback_data_mux_memory),
    .rs1_memory(rs1_memory), .rs2_memory(rs2_memory), .rd_memory(rd_memory),
    .alu_result_memory(alu_result_memory), .srcA_memory(srcA_memory), .srcB_memory(srcB_memory),
    .vector_data_memory(vector_data_memory),
    .vector_address_data_memory(vector_address_data_memory)
  );

  // Drive one decoded operation onto the Decode-side inputs.
  task automatic set_op(input logic [3:0] op, input logic wre, input logic vwre, input logic wme,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    control_in = {6'd0, 1'b0, op, 2'b00, wme, vwre, wre};
    srcA_in    = a;
    srcB_in    = b;
    rs1_decode = r1;
    rs2_decode = r2;
    rd_decode  = rd;
  endtask

  task automatic test_reset();
    set_op(4'd0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 5'd1, 5'd2, 5'd3);
    control_in[9] = 1'b1;
    srcA_vector_in = {16{8'h05}};
    srcB_vector_in = {16{8'h01}};
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;   // mid-cycle, no edge
    #1;
    if (wre_execute !== 1'b0 || load_instruction !== 1'b0 || rd_execute !== 5'd0) begin
      errors++; $display("FAIL reset_de: wre=%b load=%b rd=%0d expected 0", wre_execute, load_instruction, rd_execute);
    end
    checks++;
    if (wre_memory !== 1'b0 || alu_result_memory !== 8'h00 || srcA_memory !== 8'h00 || rd_memory !== 5'd0) begin
      errors++; $display("FAIL reset_em: wre=%b alu=%h srcA=%h rd=%0d expected 0", wre_memory, alu_result_memory, srcA_memory, rd_memory);
    end
    checks++;
    if (vector_data_memory !== 128'd0 || vector_address_data_memory !== 12'd0) begin
      errors++; $display("FAIL reset_vec: vec=%h addr=%h expected 0", vector_data_memory, vector_address_data_memory);
    end
    checks++;
    @(negedge clk); reset = 1'b0; #1;
    if (wre_execute !== 1'b0 || alu_result_memory !== 8'h00) begin
      errors++; $display("FAIL reset_release_hold: wre=%b alu=%h expected 0/00", wre_execute, alu_result_memory);
    end
    checks++;
    @(posedge clk); #1;
    if (wre_execute !== 1'b1 || load_instruction !== 1'b1 || rd_execute !== 5'd3 || wre_memory !== 1'b0) begin
      errors++; $display("FAIL reset_first_capture: wre_e=%b load=%b rd_e=%0d wre_m=%b expected 1 1 3 0",
                         wre_execute, load_instruction, rd_execute, wre_memory);
    end
    checks++;
  endtask

  task automatic test_add_sub();
    @(negedge clk); set_op(4'd0, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h20, 5'd1, 5'd2, 5'd3);
    @(posedge clk); #1;
    if (aluOp_execute !== 4'd0 || rd_execute !== 5'd3 || alu_result_execute !== 8'h10) begin
      errors++; $display("FAIL add_execute: op=%0d rd=%0d res=%h expected 0 3 10", aluOp_execute, rd_execute, alu_result_execute);
    end
    checks++;
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (alu_result_memory !== 8'h10 || wre_memory !== 1'b1 || rd_memory !== 5'd3) begin
      errors++; $display("FAIL add_wrap: res=%h wre=%b rd=%0d expected 10 1 3", alu_result_memory, wre_memory, rd_memory);
    end
    checks++;
    @(negedge clk); set_op(4'd1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h07, 5'd1, 5'd2, 5'd4);
    @(posedge clk);
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (alu_result_memory !== 8'hFE || rd_memory !== 5'd4) begin
      errors++; $display("FAIL sub_wrap: res=%h rd=%0d expected FE 4", alu_result_memory, rd_memory);
    end
    checks++;
  endtask

  task automatic test_op_sweep();
    logic [3:0] ops  [8];
    logic [7:0] exps [8];
    ops  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12};
    exps = '{8'h01, 8'hC7, 8'hC6, 8'h60, 8'h06, 8'h05, 8'hCF, 8'h00};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); set_op(ops[i], 1'b1, 1'b0, 1'b0, 8'hC3, 8'h05, 5'd1, 5'd2, 5'd5);
      @(posedge clk);
      @(negedge clk); control_in = 16'd0;
      @(posedge clk); #1;
      if (alu_result_memory !== exps[i]) begin
        errors++; $display("FAIL op_sweep op=%0d: got %h expected %h", ops[i], alu_result_memory, exps[i]);
      end
      checks++;
    end
  endtask

  task automatic test_forwarding();
    // select 1: Writeback data on A
    @(negedge clk); set_op(4'd0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 5'd1, 5'd2, 5'd6);
    @(posedge clk); #1; writeback_data = 8'h40; select_forward_mux_A = 3'd1;
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (alu_result_memory !== 8'h42 || srcA_memory !== 8'h40 || vector_address_data_memory !== 12'h040) begin
      errors++; $display("FAIL fwd_a_wb: res=%h srcA=%h addr=%h expected 42 40 040",
                         alu_result_memory, srcA_memory, vector_address_data_memory);
    end
    checks++;
    select_forward_mux_A = 3'd0;
    // select 2: prior result (0x10) from the E/M register on A
    @(negedge clk); set_op(4'd0, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h20, 5'd1, 5'd2, 5'd3);
    @(posedge clk);
    @(negedge clk); set_op(4'd0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 5'd3, 5'd2, 5'd7);
    @(posedge clk); #1; select_forward_mux_A = 3'd2;
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (alu_result_memory !== 8'h12 || srcA_memory !== 8'h10) begin
      errors++; $display("FAIL fwd_a_mem: res=%h srcA=%h expected 12 10", alu_result_memory, srcA_memory);
    end
    checks++;
    // select 5: falls back to the D/E operand
    select_forward_mux_A = 3'd5;
    @(negedge clk); set_op(4'd0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 5'd1, 5'd2, 5'd8);
    @(posedge clk);
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (alu_result_memory !== 8'h03 || srcA_memory !== 8'h01) begin
      errors++; $display("FAIL fwd_a_sel5: res=%h srcA=%h expected 03 01", alu_result_memory, srcA_memory);
    end
    checks++;
    select_forward_mux_A = 3'd0;
    // select 1 on B: store data comes from Writeback
    @(negedge clk); set_op(4'd0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 5'd1, 5'd2, 5'd9);
    @(posedge clk); #1; writeback_data = 8'h40; select_forward_mux_B = 3'd1;
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (alu_result_memory !== 8'h41 || srcB_memory !== 8'h40 || srcA_memory !== 8'h01) begin
      errors++; $display("FAIL fwd_b_wb: res=%h srcB=%h srcA=%h expected 41 40 01",
                         alu_result_memory, srcB_memory, srcA_memory);
    end
    checks++;
    select_forward_mux_B = 3'd0;
  endtask

  task automatic test_vector();
    logic [127:0] va, vb, vexp;
    for (int i = 0; i < 16; i++) begin
      va[8*i +: 8]   = 8'(i);
      vb[8*i +: 8]   = 8'h10;
      vexp[8*i +: 8] = 8'(8'h10 + i);
    end
    @(negedge clk); set_op(4'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5'd1, 5'd2, 5'd10);
    srcA_vector_in = va; srcB_vector_in = vb;
    @(posedge clk);
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (vector_data_memory !== vexp || vector_wre_memory !== 1'b1) begin
      errors++; $display("FAIL vec_add: got %h vwre=%b expected %h 1", vector_data_memory, vector_wre_memory, vexp);
    end
    checks++;
    // lane isolation: 0xFF+0x01 wraps inside each lane
    @(negedge clk); set_op(4'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5'd1, 5'd2, 5'd10);
    srcA_vector_in = {16{8'hFF}}; srcB_vector_in = {16{8'h01}};
    @(posedge clk);
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (vector_data_memory !== 128'd0) begin
      errors++; $display("FAIL vec_carry_isolation: got %h expected 0", vector_data_memory);
    end
    checks++;
    // 0x00-0x01 borrows only within each lane
    @(negedge clk); set_op(4'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5'd1, 5'd2, 5'd10);
    srcA_vector_in = 128'd0; srcB_vector_in = {16{8'h01}};
    @(posedge clk);
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (vector_data_memory !== {16{8'hFF}}) begin
      errors++; $display("FAIL vec_borrow_isolation: got %h expected all FF", vector_data_memory);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_op(4'd0, 1'b1, 1'b0, 1'b1, 8'h03, 8'h04, 5'd1, 5'd2, 5'd11);
    @(posedge clk);
    @(negedge clk); set_op(4'd4, 1'b1, 1'b0, 1'b1, 8'h0F, 8'hFF, 5'd4, 5'd5, 5'd12);
    @(posedge clk); #1;
    if (alu_result_memory !== 8'h07 || rs1_memory !== 5'd1 || rs2_memory !== 5'd2 || rd_memory !== 5'd11) begin
      errors++; $display("FAIL b2b_op1: res=%h rs1=%0d rs2=%0d rd=%0d expected 07 1 2 11",
                         alu_result_memory, rs1_memory, rs2_memory, rd_memory);
    end
    checks++;
    @(negedge clk); set_op(4'd1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h01, 5'd6, 5'd7, 5'd13);
    @(posedge clk); #1;
    if (alu_result_memory !== 8'hF0 || rs1_memory !== 5'd4 || rs2_memory !== 5'd5 || rd_memory !== 5'd12) begin
      errors++; $display("FAIL b2b_op2: res=%h rs1=%0d rs2=%0d rd=%0d expected F0 4 5 12",
                         alu_result_memory, rs1_memory, rs2_memory, rd_memory);
    end
    checks++;
    @(negedge clk); control_in = 16'd0;
    @(posedge clk); #1;
    if (alu_result_memory !== 8'h0F || rs1_memory !== 5'd6 || rs2_memory !== 5'd7 || write_memory_enable_memory !== 1'b1) begin
      errors++; $display("FAIL b2b_op3: res=%h rs1=%0d rs2=%0d wme=%b expected 0F 6 7 1",
                         alu_result_memory, rs1_memory, rs2_memory, write_memory_enable_memory);
    end
    checks++;
    @(posedge clk); #1;
    if (wre_memory !== 1'b0 || write_memory_enable_memory !== 1'b0) begin
      errors++; $display("FAIL b2b_nop: wre=%b wme=%b expected 0 0", wre_memory, write_memory_enable_memory);
    end
    checks++;
  endtask

  initial begin
    reset = 1'b1;
    control_in = 16'd0;
    srcA_in = 8'd0; srcB_in = 8'd0;
    srcA_vector_in = 128'd0; srcB_vector_in = 128'd0;
    rs1_decode = 5'd0; rs2_decode = 5'd0; rd_decode = 5'd0;
    writeback_data = 8'd0;
    select_forward_mux_A = 3'd0; select_forward_mux_B = 3'd0;
    test_reset();
    test_add_sub();
    test_op_sweep();
    test_forwarding();
    test_vector();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
